// File: rtl/msftdvip_reg_initiator.sv
// Register-bus initiator: turns one valid/ready command into a single enable/ready
// beat toward a responder, with per-beat timeout and a saturating timeout counter.
module msftdvip_reg_initiator #(
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        req_we_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        reg_en_o,
    output logic [31:0] reg_addr_o,
    output logic [31:0] reg_wdata_o,
    output logic        reg_we_o,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_ready_i,
    output logic [7:0]  timeout_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      state_r;
    logic        req_ready_r;
    logic        reg_en_r;
    logic        reg_we_r;
    logic [31:0] reg_addr_r;
    logic [31:0] reg_wdata_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  timeout_cnt_r;
    logic        wait_expire_s;

    // This stalled cycle is the TIMEOUT_CYCLES-th one; a handshake in the same cycle still wins.
    assign wait_expire_s = (({1'b0, wait_cnt_r} + 9'd1) >= {1'b0, TIMEOUT_CYCLES});

    // Transaction FSM with every output held in a register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= IDLE;
            req_ready_r   <= 1'b0;
            reg_en_r      <= 1'b0;
            reg_we_r      <= 1'b0;
            reg_addr_r    <= 32'd0;
            reg_wdata_r   <= 32'd0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= 32'd0;
            rsp_err_r     <= 1'b0;
            wait_cnt_r    <= 8'd0;
            timeout_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid_i && req_ready_r) begin
                        reg_addr_r  <= req_addr_i;
                        reg_wdata_r <= req_wdata_i;
                        reg_we_r    <= req_we_i;
                        reg_en_r    <= 1'b1;
                        req_ready_r <= 1'b0;
                        wait_cnt_r  <= 8'd0;
                        state_r     <= ISSUE;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (reg_ready_i) begin
                        reg_en_r <= 1'b0;
                        reg_we_r <= 1'b0;
                        if (reg_we_r) begin
                            rsp_valid_r <= 1'b1;
                            rsp_rdata_r <= 32'd0;
                            rsp_err_r   <= 1'b0;
                            state_r     <= RESP;
                        end else begin
                            state_r <= CAPTURE;
                        end
                    end else if (wait_expire_s) begin
                        reg_en_r    <= 1'b0;
                        reg_we_r    <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_rdata_r <= reg_we_r ? 32'd0 : ERR_RDATA;
                        if (timeout_cnt_r != 8'hFF) begin
                            timeout_cnt_r <= timeout_cnt_r + 8'd1;
                        end else begin
                            timeout_cnt_r <= timeout_cnt_r;
                        end
                        state_r <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                CAPTURE: begin
                    rsp_rdata_r <= reg_rdata_i;
                    rsp_err_r   <= 1'b0;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RESP;
                end
                RESP: begin
                    // req_ready stays low here so the next command waits one extra cycle.
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b0;
                    reg_en_r    <= 1'b0;
                    reg_we_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_r;
    assign reg_en_o      = reg_en_r;
    assign reg_we_o      = reg_we_r;
    assign reg_addr_o    = reg_addr_r;
    assign reg_wdata_o   = reg_wdata_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_rdata_o   = rsp_rdata_r;
    assign rsp_err_o     = rsp_err_r;
    assign timeout_cnt_o = timeout_cnt_r;

endmodule

// File: doc/msftdvip_reg_initiator.md
MSFTDVIP_REG_INITIATOR -- requirements
Module: msftDvIp_reg_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8'd64: number of ISSUE cycles without reg_ready_i before abort; legal range 1..255.
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_i  input  1  sole clock, all state on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 req_valid_i  input  1  command valid.
REQ-007 req_ready_o  output  1  command accepted when valid&ready.
REQ-008 req_addr_i  input  32  command address.
REQ-009 req_wdata_i  input  32  command write data.
REQ-010 req_we_i  input  1  1=write, 0=read.
REQ-011 rsp_valid_o  output  1  response valid.
REQ-012 rsp_ready_i  input  1  response consumed when valid&ready.
REQ-013 rsp_rdata_o  output  32  read data (0 for writes).
REQ-014 rsp_err_o  output  1  transaction timed out.
REQ-015 reg_en_o  output  1  register-bus enable toward responder.
REQ-016 reg_addr_o  output  32  register-bus address.
REQ-017 reg_wdata_o  output  32  register-bus write data.
REQ-018 reg_we_o  output  1  register-bus write strobe.
REQ-019 reg_rdata_i  input  32  responder read data, valid the cycle after the accepting beat.
REQ-020 reg_ready_i  input  1  responder accepts the beat while reg_en_o high.
REQ-021 timeout_cnt_o  output  8  saturating count of timed-out transactions.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP; one transaction in flight at a time.
REQ-023 req_ready_o SHALL be 1 only in IDLE; accepting a command latches addr/wdata/we and moves to ISSUE.
REQ-024 In ISSUE, reg_en_o=1 and reg_addr_o/reg_wdata_o/reg_we_o SHALL hold the latched values, stable until exit from ISSUE.
REQ-025 Beat completes on the edge where reg_en_o&reg_ready_i; read -> CAPTURE, write -> RESP with rsp_rdata_o=0, rsp_err_o=0.
REQ-026 In CAPTURE (exactly one cycle, reg_en_o=0), reg_rdata_i SHALL be registered into rsp_rdata_o; next state RESP, rsp_err_o=0.
REQ-027 Latency: command accepted at edge N -> reg_en_o high cycle N+1; with immediate reg_ready_i, write rsp_valid_o from N+2, read rsp_valid_o from N+3.
REQ-028 ISSUE SHALL count cycles with reg_ready_i=0; when count reaches TIMEOUT_CYCLES, drop reg_en_o, go RESP with rsp_err_o=1, rsp_rdata_o=ERR_RDATA (reads) or 0 (writes), and increment timeout_cnt_o saturating at 255.
REQ-029 reg_ready_i asserted in the same cycle the count reaches TIMEOUT_CYCLES SHALL complete normally (handshake wins over timeout).
REQ-030 In RESP, rsp_valid_o=1 with rsp_rdata_o/rsp_err_o stable until rsp_ready_i; on handshake go IDLE.
REQ-031 req_ready_o SHALL NOT be asserted in the handshake cycle of RESP (no same-cycle turnaround); next command accepted no earlier than the following cycle.
REQ-032 reg_en_o SHALL be 0 in every state except ISSUE; reg_we_o SHALL be 0 whenever reg_en_o=0.
REQ-033 All outputs SHALL be driven from registers or direct state decode; no combinational path from any input to any output.

Reset
REQ-034 On rising edge with rst_i=1: state=IDLE, reg_en_o=0, reg_we_o=0, reg_addr_o=0, reg_wdata_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, timeout counter=0, timeout_cnt_o=0; req_ready_o=1 the cycle after rst_i deasserts.
REQ-035 Reset mid-transaction SHALL abandon it with no response; reg_en_o low from the reset edge.

Verification
REQ-036 Write 0x4001_0000<=0x1234_5678, reg_ready_i=1 -> reg_en_o/reg_we_o one cycle with those values; rsp_valid_o at N+2, rsp_err_o=0, rsp_rdata_o=0.
REQ-037 Read 0x4000_0004, reg_ready_i=1, reg_rdata_i=0xCAFE_0001 the following cycle -> rsp_valid_o at N+3, rsp_rdata_o=0xCAFE_0001.
REQ-038 Read with reg_ready_i low 3 cycles then high -> reg_en_o held 4 cycles, addr stable, normal response, timeout_cnt_o unchanged.
REQ-039 TIMEOUT_CYCLES=4, reg_ready_i stuck 0 on read -> reg_en_o drops after 4 cycles; rsp_err_o=1, rsp_rdata_o=0xDEAD_BEEF, timeout_cnt_o=1; 256 timeouts -> timeout_cnt_o=255.
REQ-040 rsp_ready_i held 0 for 5 cycles with req_valid_i=1 -> response stable, req_ready_o=0, no new reg_en_o until after handshake.
REQ-041 rst_i=1 during ISSUE -> reg_en_o=0 after that edge, no rsp_valid_o, all REQ-034 values.
